// File: rtl/regbank_wr_arb_pkg.sv
// Shared types and defaults for the register-bank write arbiter.
package regbank_wr_arb_pkg;
  localparam int N_REQ_DEF = 3;
  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 5;

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  // Index width for a requester count; never zero so N_REQ=1 still builds.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regbank_wr_arb_rr_pick.sv
// Combinational round-robin search: first eligible index after LAST, wrapping.
module rr_pick
  import regbank_wr_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    winner,
  output logic             valid
);
  logic [IW-1:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last) + k) % N_REQ);
      if (!valid && eligible[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end
endmodule

// File: rtl/regbank_wr_arb.sv
// Round-robin write arbiter driving a register bank, with a full-bank clear sweep.
// Define WRARB_R0_PROTECT_EN to make register 0 read-only (writes acked, CE suppressed).
module regbank_wr_arb
  import regbank_wr_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [N_REQ*AW-1:0] ADDR,
  input  logic [N_REQ*DW-1:0] WDATA,
  input  logic               CLR,
  output logic [N_REQ-1:0]   ACK,
  output logic [2**AW-1:0]   CE,
  output logic [DW-1:0]      DI,
  output logic               BUSY
);
  localparam int NR = 2**AW;
  localparam int IW = idx_w(N_REQ);

  state_t        state, state_d;
  logic [AW-1:0] cnt, cnt_d;
  logic [IW-1:0] last, last_d, win;
  logic          win_vld;
  logic [AW-1:0] waddr;
  logic [NR-1:0] ce_d;
  logic [DW-1:0] di_d;
  logic [N_REQ-1:0] ack_d;
  logic          busy_d;

  // Masking with ACK keeps a held request from being granted on back-to-back cycles.
  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .eligible(REQ & ~ACK),
    .last    (last),
    .winner  (win),
    .valid   (win_vld)
  );

  assign waddr = ADDR[int'(win)*AW +: AW];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= IW'(N_REQ-1);
      CE    <= '0;
      DI    <= '0;
      ACK   <= '0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      last  <= last_d;
      CE    <= ce_d;
      DI    <= di_d;
      ACK   <= ack_d;
      BUSY  <= busy_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    last_d  = last;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (CLR) state_d = SWEEP;
        else if (win_vld) last_d = win;
      end
      SWEEP: begin
        if (cnt == '1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so these are the values for the cycle after the edge;
  // CE index during a sweep therefore tracks cnt as it will be after the edge.
  always_comb begin
    ce_d   = '0;
    di_d   = DI;
    ack_d  = '0;
    busy_d = 1'b0;
    case (state)
      IDLE: begin
        if (CLR) begin
          ce_d   = NR'(1);
          di_d   = '0;
          busy_d = 1'b1;
        end else if (win_vld) begin
          ack_d = N_REQ'(1) << win;
          di_d  = WDATA[int'(win)*DW +: DW];
`ifdef WRARB_R0_PROTECT_EN
          if (waddr != '0) ce_d = NR'(1) << waddr;
`else
          ce_d = NR'(1) << waddr;
`endif
        end
      end
      SWEEP: begin
        di_d = '0;
        if (cnt != '1) begin
          ce_d   = NR'(1) << (cnt + 1'b1);
          busy_d = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_regbank_wr_arb.sv
// Self-checking bench for regbank_wr_arb: directed scenarios plus randomized traffic vs a cycle model.
module tb_regbank_wr_arb;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
`ifdef WRARB_R0_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic          CLK, RST, CLR;
  logic [N-1:0]  REQ;
  logic [N*AW-1:0] ADDR;
  logic [N*DW-1:0] WDATA;
  logic [N-1:0]  ACK;
  logic [NR-1:0] CE;
  logic [DW-1:0] DI;
  logic          BUSY;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int            m_sweep;   // -1 when idle, else register index being cleared this cycle
  int            m_last;
  logic [NR-1:0] e_ce;
  logic [DW-1:0] e_di;
  logic [N-1:0]  e_ack;
  logic          e_busy;

  regbank_wr_arb dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .ADDR(ADDR), .WDATA(WDATA), .CLR(CLR),
    .ACK(ACK), .CE(CE), .DI(DI), .BUSY(BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic model_reset();
    m_sweep = -1;
    m_last  = N - 1;
    e_ce    = '0;
    e_di    = '0;
    e_ack   = '0;
    e_busy  = 1'b0;
  endtask

  // Predict the outputs for the next cycle from the inputs now on the pins, then clock.
  task automatic tick();
    int w;
    bit found;
    logic [AW-1:0] a;
    found = 1'b0;
    w = 0;
    if (m_sweep >= 0) begin
      e_ack = '0;
      e_di  = '0;
      e_ce  = '0;
      if (m_sweep == NR - 1) begin
        m_sweep = -1;
        e_busy  = 1'b0;
      end else begin
        m_sweep++;
        e_ce[m_sweep] = 1'b1;
        e_busy = 1'b1;
      end
    end else if (CLR) begin
      m_sweep = 0;
      e_ce = '0;
      e_ce[0] = 1'b1;
      e_di = '0;
      e_ack = '0;
      e_busy = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (!found && REQ[i] && !e_ack[i]) begin
          found = 1'b1;
          w = i;
        end
      end
      e_ce = '0;
      e_ack = '0;
      e_busy = 1'b0;
      if (found) begin
        e_ack[w] = 1'b1;
        a = ADDR[w*AW +: AW];
        if (!(PROT && a == 0)) e_ce[a] = 1'b1;
        e_di = WDATA[w*DW +: DW];
        m_last = w;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; CLR = 1'b0; REQ = '0; ADDR = '0; WDATA = '0;
    model_reset();
    #22;
    n_cmp++; if (CE !== '0)   begin n_err++; $display("FAIL reset_ce: got %h exp 0", CE); end
    n_cmp++; if (DI !== '0)   begin n_err++; $display("FAIL reset_di: got %h exp 0", DI); end
    n_cmp++; if (ACK !== '0)  begin n_err++; $display("FAIL reset_ack: got %b exp 0", ACK); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", BUSY); end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_order();
    logic [N-1:0] exp_ack;
    REQ = 3'b111;
    ADDR[0 +: AW] = 5'd3; ADDR[AW +: AW] = 5'd9; ADDR[2*AW +: AW] = 5'd20;
    for (int i = 0; i < N; i++) WDATA[i*DW +: DW] = $urandom;
    for (int c = 0; c < N; c++) begin
      tick();
      exp_ack = 3'b001 << c;
      n_cmp++; if (ACK !== exp_ack) begin n_err++; $display("FAIL order_ack%0d: got %b exp %b", c, ACK, exp_ack); end
      n_cmp++; if (CE !== e_ce) begin n_err++; $display("FAIL order_ce%0d: got %h exp %h", c, CE, e_ce); end
      n_cmp++; if (DI !== e_di) begin n_err++; $display("FAIL order_di%0d: got %h exp %h", c, DI, e_di); end
      REQ = REQ & ~ACK;
    end
    REQ = '0;
    tick();
    n_cmp++; if (ACK !== '0) begin n_err++; $display("FAIL order_idle_ack: got %b exp 0", ACK); end
  endtask

  task automatic test_back_to_back();
    int n_ack;
    bit prev;
    n_ack = 0; prev = 1'b0;
    REQ = 3'b010;
    ADDR[AW +: AW] = 5'd7;
    WDATA[DW +: DW] = 32'hDEADBEEF;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++; if (ACK !== e_ack) begin n_err++; $display("FAIL b2b_ack%0d: got %b exp %b", c, ACK, e_ack); end
      n_cmp++; if (CE !== e_ce) begin n_err++; $display("FAIL b2b_ce%0d: got %h exp %h", c, CE, e_ce); end
      n_cmp++; if (ACK[1] && (CE !== 32'h80 || DI !== 32'hDEADBEEF)) begin
        n_err++; $display("FAIL b2b_write%0d: got ce %h di %h exp ce 80 di deadbeef", c, CE, DI);
      end
      n_cmp++; if (prev && ACK[1]) begin n_err++; $display("FAIL b2b_consec%0d: got two acks exp gap", c); end
      prev = ACK[1];
      if (ACK[1]) n_ack++;
    end
    n_cmp++; if (n_ack != 5) begin n_err++; $display("FAIL b2b_count: got %0d exp 5", n_ack); end
    REQ = '0;
    tick();
  endtask

  // Runs a sweep from the CLR edge; pulse_at >= 0 re-asserts CLR for one cycle mid-sweep.
  task automatic run_sweep(input string nm, input int pulse_at);
    int nb;
    nb = 0;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    n_cmp++; if (ACK !== '0) begin n_err++; $display("FAIL %s_clr_ack: got %b exp 0", nm, ACK); end
    for (int c = 0; c < 40 && BUSY === 1'b1; c++) begin
      n_cmp++; if (CE !== (32'd1 << c)) begin n_err++; $display("FAIL %s_ce%0d: got %h exp %h", nm, c, CE, 32'd1 << c); end
      n_cmp++; if (DI !== '0 || ACK !== '0) begin n_err++; $display("FAIL %s_di_ack%0d: got di %h ack %b exp 0", nm, c, DI, ACK); end
      nb++;
      CLR = (c == pulse_at);
      tick();
    end
    CLR = 1'b0;
    n_cmp++; if (nb != NR) begin n_err++; $display("FAIL %s_len: got %0d exp %0d", nm, nb, NR); end
  endtask

  task automatic test_clear();
    bit got;
    got = 1'b0;
    REQ = 3'b001;
    ADDR[0 +: AW] = 5'd5;
    WDATA[0 +: DW] = 32'hA5A5_0F0F;
    run_sweep("clear", -1);
    for (int c = 0; c < 3 && !got; c++) begin
      tick();
      n_cmp++; if (ACK !== e_ack) begin n_err++; $display("FAIL clear_after_ack%0d: got %b exp %b", c, ACK, e_ack); end
      if (ACK[0]) begin
        got = 1'b1;
        n_cmp++; if (CE !== 32'h20 || DI !== 32'hA5A5_0F0F) begin
          n_err++; $display("FAIL clear_after_wr: got ce %h di %h exp ce 20 di a5a50f0f", CE, DI);
        end
      end
    end
    n_cmp++; if (!got) begin n_err++; $display("FAIL clear_ack0: got none exp ack[0] after sweep"); end
    REQ = '0;
    tick();
  endtask

  task automatic test_mid_clr();
    run_sweep("midclr", 5);
    tick();
  endtask

  task automatic test_reset_mid();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    n_cmp++; if (CE !== (32'd1 << 10) || BUSY !== 1'b1) begin
      n_err++; $display("FAIL rstmid_step: got ce %h busy %b exp ce 400 busy 1", CE, BUSY);
    end
    #2;
    RST = 1'b0;
    #1;
    n_cmp++; if (CE !== '0 || DI !== '0 || ACK !== '0 || BUSY !== 1'b0) begin
      n_err++; $display("FAIL rstmid_async: got ce %h di %h ack %b busy %b exp all 0", CE, DI, ACK, BUSY);
    end
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
    tick();
    n_cmp++; if (BUSY !== 1'b0 || CE !== '0) begin n_err++; $display("FAIL rstmid_idle: got busy %b ce %h exp 0", BUSY, CE); end
    REQ = 3'b101;
    ADDR[0 +: AW] = 5'd1;
    WDATA[0 +: DW] = 32'h0000_1111;
    tick();
    n_cmp++; if (ACK !== 3'b001) begin n_err++; $display("FAIL rstmid_prio: got %b exp 001", ACK); end
    REQ = '0;
    tick();
    tick();
  endtask

  task automatic test_r0();
    REQ = 3'b100;
    ADDR[2*AW +: AW] = 5'd0;
    WDATA[2*DW +: DW] = 32'h1234;
    tick();
    n_cmp++; if (ACK !== 3'b100) begin n_err++; $display("FAIL r0_ack: got %b exp 100", ACK); end
    n_cmp++; if (CE !== (PROT ? 32'h0 : 32'h1)) begin n_err++; $display("FAIL r0_ce: got %h exp %h", CE, PROT ? 32'h0 : 32'h1); end
    n_cmp++; if (!PROT && DI !== 32'h1234) begin n_err++; $display("FAIL r0_di: got %h exp 1234", DI); end
    REQ = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      CLR = ($urandom_range(0, 39) == 0);
      tick();
      n_cmp++; if (ACK !== e_ack) begin n_err++; $display("FAIL rnd_ack@%0d: got %b exp %b", c, ACK, e_ack); end
      n_cmp++; if (CE !== e_ce) begin n_err++; $display("FAIL rnd_ce@%0d: got %h exp %h", c, CE, e_ce); end
      n_cmp++; if (DI !== e_di) begin n_err++; $display("FAIL rnd_di@%0d: got %h exp %h", c, DI, e_di); end
      n_cmp++; if (BUSY !== e_busy) begin n_err++; $display("FAIL rnd_busy@%0d: got %b exp %b", c, BUSY, e_busy); end
      n_cmp++; if ($countones(CE) > 1) begin n_err++; $display("FAIL rnd_onehot@%0d: got %h exp at most one bit", c, CE); end
      // Requesters hold until acked, then may issue a fresh write.
      for (int i = 0; i < N; i++) begin
        if (ACK[i] || !REQ[i]) begin
          REQ[i] = ($urandom_range(0, 2) != 0);
          ADDR[i*AW +: AW] = AW'($urandom);
          WDATA[i*DW +: DW] = $urandom;
        end
      end
    end
    CLR = 1'b0;
    REQ = '0;
  endtask

  initial begin
    test_reset();
    test_order();
    test_back_to_back();
    test_clear();
    test_mid_clr();
    test_r0();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
